// File: rtl/sel_split_n_if.sv
// Token/credit handshake bundle between sel_split_n, its upstream source and its output branches.
interface sel_split_n_if #(
  parameter int unsigned NUM_OUT = 4
);
  logic               i_drive;
  logic [NUM_OUT-1:0] i_valid;
  logic [NUM_OUT-1:0] i_freeNext;
  logic [NUM_OUT-1:0] o_driveNext;
  logic               o_free;
  logic               o_busy;
  logic               o_err;
  logic               o_timeout;

  modport master (
    output i_drive, i_valid, i_freeNext,
    input  o_driveNext, o_free, o_busy, o_err, o_timeout
  );

  modport slave (
    input  i_drive, i_valid, i_freeNext,
    output o_driveNext, o_free, o_busy, o_err, o_timeout
  );
endinterface

// File: rtl/sel_split_n.sv
// One-to-N token splitter with per-branch credit bits and a delayed upstream release.
// Optional credit-wait timeout flag enabled by defining SEL_SPLIT_TIMEOUT_EN.
module sel_split_n #(
  parameter int unsigned NUM_OUT  = 4,
  parameter int unsigned FREE_DLY = 2,
  parameter int unsigned TO_CYC   = 255
) (
  input logic          clk,
  input logic          rst,
  sel_split_n_if.slave bus
);

  localparam int unsigned SelW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int unsigned DlyW = $clog2(FREE_DLY + 2);
  localparam logic [DlyW-1:0]    DlyIssue = DlyW'(FREE_DLY);
  // Error path skips ISSUE, so it waits one extra cycle to keep o_free at t+1+FREE_DLY.
  localparam logic [DlyW-1:0]    DlyErr   = DlyW'(FREE_DLY + 1);
  localparam logic [DlyW-1:0]    DlyOne   = DlyW'(1);
  localparam logic [NUM_OUT-1:0] Lsb      = {{(NUM_OUT-1){1'b0}}, 1'b1};

  if (NUM_OUT < 2 || NUM_OUT > 16 || FREE_DLY < 1 || FREE_DLY > 15 ||
      TO_CYC < 1 || TO_CYC > 65535) begin : g_param_check
    $error("sel_split_n: parameter out of legal range");
  end

  typedef enum logic [1:0] {StIdle, StWaitRdy, StIssue, StFreeDly} state_e;

  state_e             state_q, state_d;
  logic [SelW-1:0]    sel_q, sel_d;
  logic [DlyW-1:0]    dly_q, dly_d;
  logic [NUM_OUT-1:0] rdy_q, rdy_d;
  logic [NUM_OUT-1:0] drv_q, drv_d;
  logic               free_q, free_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [SelW-1:0]    vld_idx;
  logic               vld_onehot;

  always_comb begin
    vld_idx = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (bus.i_valid[k]) vld_idx = SelW'(k);
    end
    vld_onehot = (bus.i_valid != '0) && ((bus.i_valid & (bus.i_valid - Lsb)) == '0);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dly_d   = dly_q;
    drv_d   = '0;
    err_d   = err_q;
    // A credit on an already-ready branch is a duplicate: flag it, the bit simply stays set.
    rdy_d   = rdy_q | bus.i_freeNext;
    if ((bus.i_freeNext & rdy_q) != '0) err_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.i_drive) begin
          if (vld_onehot) begin
            sel_d = vld_idx;
            if (rdy_q[vld_idx]) begin
              state_d = StIssue;
              drv_d   = Lsb << vld_idx;
            end else begin
              state_d = StWaitRdy;
            end
          end else begin
            err_d   = 1'b1;
            state_d = StFreeDly;
            dly_d   = DlyErr;
          end
        end
      end
      StWaitRdy: begin
        if (rdy_q[sel_q]) begin
          state_d = StIssue;
          drv_d   = Lsb << sel_q;
        end
      end
      StIssue: begin
        rdy_d[sel_q] = bus.i_freeNext[sel_q];
        state_d      = StFreeDly;
        dly_d        = DlyIssue;
      end
      StFreeDly: begin
        dly_d = (dly_q != '0) ? dly_q - DlyOne : '0;
        if (dly_q <= DlyOne) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus.i_drive && state_q != StIdle) err_d = 1'b1;

    free_d = (state_d == StFreeDly) && (dly_d == DlyOne);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      dly_q   <= '0;
      rdy_q   <= '1;
      drv_q   <= '0;
      free_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dly_q   <= dly_d;
      rdy_q   <= rdy_d;
      drv_q   <= drv_d;
      free_q  <= free_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_driveNext = drv_q;
  assign bus.o_free      = free_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_err       = err_q;

`ifdef SEL_SPLIT_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        to_q, to_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    to_d     = to_q;
    if (state_q == StWaitRdy) begin
      if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 16'd1;
      if (({1'b0, to_cnt_q} + 17'd1) >= 17'(TO_CYC)) to_d = 1'b1;
    end else if (state_d == StWaitRdy) begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_q     <= to_d;
    end
  end

  assign bus.o_timeout = to_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sel_split_n.sv
// Directed bench for sel_split_n (NUM_OUT=4, FREE_DLY=2, TO_CYC=8): expected drive/free events
// are queued with their cycle numbers and matched by a monitor on the falling edge.
module tb_sel_split_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int         c;
    logic [3:0] v;
  } drv_t;

  drv_t drv_exp_q[$];
  int   free_exp_q[$];
  drv_t mon_e;
  int   mon_f;
  logic prev_free = 1'b0;

  sel_split_n_if #(.NUM_OUT(4)) bus ();

  sel_split_n #(
    .NUM_OUT (4),
    .FREE_DLY(2),
    .TO_CYC  (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(int n);
    while (cyc < n) step();
  endtask

  task automatic drive(logic [3:0] v);
    bus.i_drive = 1'b1;
    bus.i_valid = v;
    step();
    bus.i_drive = 1'b0;
    bus.i_valid = 4'($urandom);
  endtask

  task automatic credit(logic [3:0] v);
    bus.i_freeNext = v;
    step();
    bus.i_freeNext = '0;
  endtask

  task automatic exp_drv(int c, logic [3:0] v);
    drv_exp_q.push_back('{c: c, v: v});
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_drv"}, 32'(bus.o_driveNext), 0);
    chk({tag, "_free"}, 32'(bus.o_free), 0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 0);
    chk({tag, "_err"}, 32'(bus.o_err), 0);
    chk({tag, "_timeout"}, 32'(bus.o_timeout), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (drv_exp_q.size() > 0 && drv_exp_q[0].c < cyc) begin
        mon_e = drv_exp_q.pop_front();
        chk("drive_missing", 32'(cyc), 32'(mon_e.c));
      end
      if (free_exp_q.size() > 0 && free_exp_q[0] < cyc) begin
        mon_f = free_exp_q.pop_front();
        chk("free_missing", 32'(cyc), 32'(mon_f));
      end
      if (bus.o_driveNext !== 4'b0000) begin
        chk("drive_onehot", 32'($onehot0(bus.o_driveNext)), 1);
        if (drv_exp_q.size() == 0) begin
          chk("drive_unexpected", 32'(bus.o_driveNext), 0);
        end else begin
          mon_e = drv_exp_q.pop_front();
          chk("drive_cycle", 32'(cyc), 32'(mon_e.c));
          chk("drive_value", 32'(bus.o_driveNext), 32'(mon_e.v));
        end
      end
      if (bus.o_free === 1'b1) begin
        chk("free_not_back_to_back", 32'(prev_free), 0);
        if (free_exp_q.size() == 0) begin
          chk("free_unexpected", 32'(bus.o_free), 0);
        end else begin
          mon_f = free_exp_q.pop_front();
          chk("free_cycle", 32'(cyc), 32'(mon_f));
        end
      end
    end
    prev_free = bus.o_free;
  end

  initial begin
    bus.i_drive    = 1'b0;
    bus.i_valid    = '0;
    bus.i_freeNext = '0;

    // Pulses while in reset must be ignored.
    go(1);
    bus.i_drive    = 1'b1;
    bus.i_valid    = 4'b0001;
    bus.i_freeNext = 4'b1111;
    step();
    bus.i_drive    = 1'b0;
    bus.i_freeNext = '0;
    chk_all_zero("reset");
    go(4);
    rst = 1'b0;
    go(5);
    chk("post_reset_err", 32'(bus.o_err), 0);
    chk("post_reset_busy", 32'(bus.o_busy), 0);

    // Credit available: drive at 10 -> issue at 11, free at 13.
    go(10);
    exp_drv(11, 4'b0100);
    free_exp_q.push_back(13);
    drive(4'b0100);
    chk("issue_busy", 32'(bus.o_busy), 1);
    go(14);
    chk("issue_err", 32'(bus.o_err), 0);
    chk("issue_idle", 32'(bus.o_busy), 0);

    // No credit on branch 2: wait, then credit at 30 -> issue at 32, free at 34.
    go(20);
    drive(4'b0100);
    for (int c = 21; c <= 29; c++) begin
      go(c);
      chk("wait_busy", 32'(bus.o_busy), 1);
`ifdef SEL_SPLIT_TIMEOUT_EN
      chk("wait_timeout", 32'(bus.o_timeout), (c >= 29) ? 1 : 0);
`else
      chk("wait_timeout", 32'(bus.o_timeout), 0);
`endif
    end
    go(30);
    exp_drv(32, 4'b0100);
    free_exp_q.push_back(34);
    credit(4'b0100);
    go(35);
    chk("credit_err", 32'(bus.o_err), 0);
    chk("credit_idle", 32'(bus.o_busy), 0);

    // Zero i_valid: error, no drive, free still released at 43.
    go(40);
    free_exp_q.push_back(43);
    drive(4'b0000);
    chk("zero_valid_err", 32'(bus.o_err), 1);
    go(45);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Multi-hot i_valid: same handling.
    go(50);
    chk("multi_pre_err", 32'(bus.o_err), 0);
    free_exp_q.push_back(53);
    drive(4'b0110);
    chk("multi_valid_err", 32'(bus.o_err), 1);
    chk("multi_valid_busy", 32'(bus.o_busy), 1);
    go(55);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Second drive during FREE_DLY is flagged and ignored.
    go(60);
    exp_drv(61, 4'b0001);
    free_exp_q.push_back(63);
    drive(4'b0001);
    go(62);
    chk("dup_drive_pre_err", 32'(bus.o_err), 0);
    drive(4'b0010);
    chk("dup_drive_err", 32'(bus.o_err), 1);
    go(66);
    credit(4'b0001);
    exp_drv(68, 4'b0001);
    free_exp_q.push_back(70);
    drive(4'b0001);
    go(72);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Duplicate credit on a ready branch: error, rdy[0] still set.
    go(75);
    chk("dup_credit_pre_err", 32'(bus.o_err), 0);
    go(77);
    credit(4'b0001);
    chk("dup_credit_err", 32'(bus.o_err), 1);
    go(82);
    exp_drv(83, 4'b0001);
    free_exp_q.push_back(85);
    drive(4'b0001);

    // Reset during WAIT_RDY drops the token; rdy returns to all ones.
    go(90);
    drive(4'b0001);
    go(94);
    chk("wait_before_reset_busy", 32'(bus.o_busy), 1);
    go(95);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("mid_reset");
    go(100);
    exp_drv(101, 4'b0001);
    free_exp_q.push_back(103);
    drive(4'b0001);

    go(110);
    chk("drive_queue_empty", 32'(drv_exp_q.size()), 0);
    chk("free_queue_empty", 32'(free_exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sel_split_n.md
SEL_SPLIT_N -- requirements
Module: sel_split_n

Interface
REQ-001 Parameter NUM_OUT, default 4, number of output branches; legal range 2..16.
REQ-002 Parameter FREE_DLY, default 2, cycles from o_driveNext pulse to o_free pulse; legal range 1..15.
REQ-003 Parameter TO_CYC, default 255, cycles in WAIT_RDY before timeout flags; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_drive  input  1  one-cycle token-arrival pulse from upstream.
REQ-007 i_valid  input  NUM_OUT  branch select, sampled only in the i_drive cycle; one-hot is legal.
REQ-008 i_freeNext  input  NUM_OUT  one-cycle credit pulse per branch from downstream.
REQ-009 o_driveNext  output  NUM_OUT  one-cycle token pulse to the selected branch.
REQ-010 o_free  output  1  one-cycle pulse releasing upstream.
REQ-011 o_busy  output  1  high whenever state is not IDLE.
REQ-012 o_err  output  1  sticky protocol-error flag.
REQ-013 o_timeout  output  1  sticky credit-wait timeout flag.

Function
REQ-014 The block SHALL hold one credit bit rdy[k] per branch; rdy[k] = 1 means branch k can accept a token.
REQ-015 A pulse on i_freeNext[k] SHALL set rdy[k] at the next edge.
REQ-016 A pulse on i_freeNext[k] while rdy[k] = 1 SHALL also set o_err; in that case rdy[k] stays 1.
REQ-017 The FSM SHALL have exactly four states: IDLE, WAIT_RDY, ISSUE and FREE_DLY.
REQ-018 In IDLE, i_drive with a one-hot i_valid SHALL latch the branch index into sel.
REQ-019 From IDLE on that event, the FSM SHALL go to ISSUE if rdy[sel] = 1, otherwise to WAIT_RDY.
REQ-020 In IDLE, i_drive with i_valid zero or multi-hot SHALL set o_err and go to FREE_DLY with no o_driveNext pulse, so upstream is still freed.
REQ-021 In WAIT_RDY, the FSM SHALL move to ISSUE on the first cycle in which the registered rdy[sel] = 1.
REQ-022 In ISSUE, the block SHALL assert o_driveNext[sel] for exactly one cycle, clear rdy[sel], load the delay counter with FREE_DLY and go to FREE_DLY.
REQ-023 In FREE_DLY, the counter SHALL decrement each cycle; o_free SHALL be asserted in the cycle the counter equals 1; the FSM SHALL then enter IDLE.
REQ-024 Latency with credit available: i_drive in cycle t SHALL give o_driveNext in t+1 and o_free in t+1+FREE_DLY.
REQ-025 Latency without credit: i_freeNext[sel] in cycle c SHALL give o_driveNext in c+2.
REQ-026 i_drive in any state other than IDLE SHALL set o_err and SHALL otherwise be ignored.
REQ-027 i_drive is accepted no earlier than the cycle after o_free.
REQ-028 At most one bit of o_driveNext SHALL be high in any cycle.
REQ-029 o_free SHALL never be asserted in two consecutive cycles.
REQ-030 i_valid SHALL be ignored outside the i_drive cycle.
REQ-031 The delay and timeout counters SHALL saturate and never wrap.

Reset
REQ-032 While rst is high, the block SHALL set state = IDLE, sel = 0, all counters = 0, rdy = all ones, and o_driveNext, o_free, o_busy, o_err and o_timeout = 0.
REQ-033 A reset asserted mid-operation SHALL drop the in-flight token with no o_driveNext and no o_free pulse.
REQ-034 Pulses on i_drive and i_freeNext in any cycle with rst high SHALL be ignored.

Configuration
REQ-035 The timeout feature SHALL be controlled by macro SEL_SPLIT_TIMEOUT_EN.
REQ-036 With SEL_SPLIT_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_RDY and increment each cycle in WAIT_RDY.
REQ-037 With SEL_SPLIT_TIMEOUT_EN defined, reaching TO_CYC SHALL set o_timeout (sticky until rst); the FSM SHALL keep waiting and SHALL NOT drop the token.
REQ-038 With SEL_SPLIT_TIMEOUT_EN undefined, o_timeout SHALL be tied to 0, no timeout counter SHALL exist, and the port list SHALL be unchanged.

Verification
REQ-039 Scenario: NUM_OUT=4, FREE_DLY=2; after reset, i_drive at cycle 10 with i_valid=0100 -> o_driveNext=0100 at cycle 11, o_free at cycle 13, rdy[2]=0.
REQ-040 Scenario: repeat i_drive with i_valid=0100 while rdy[2]=0 -> o_busy high and no o_driveNext; i_freeNext[2] at cycle 30 -> o_driveNext=0100 at cycle 32, o_free at cycle 34.
REQ-041 Scenario: i_drive with i_valid=0000, then with i_valid=0110 -> each gives o_err=1, no o_driveNext, o_free 1+FREE_DLY cycles after i_drive.
REQ-042 Scenario: second i_drive during FREE_DLY, and i_freeNext[0] while rdy[0]=1 -> o_err=1; token count and rdy otherwise unchanged.
REQ-043 Scenario: rst high during WAIT_RDY -> next cycle all outputs 0, rdy all ones, no o_free ever emitted for the dropped token.
REQ-044 Scenario: with SEL_SPLIT_TIMEOUT_EN and TO_CYC=8, withhold credit -> o_timeout rises 8 cycles after WAIT_RDY entry; a later i_freeNext still completes the token; without the macro o_timeout stays 0.
